// File: rtl/iram_pkg.sv
// rtl/iram_pkg.sv - shared types and sizing helpers for the loadable instruction memory
//
// Purpose : FSM state encoding plus the bytes-per-word, byte-counter-width
//           and memory-index-width helpers used by iram_prog and iram_core.
// Ports   : none (package)
package iram_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bytes per instruction word.
  function automatic int bpw(input int instr_w);
    return instr_w / 8;
  endfunction

  // Width of the byte-within-word counter; never less than one bit.
  function automatic int bcnt_w(input int instr_w);
    return (instr_w / 8 <= 1) ? 1 : $clog2(instr_w / 8);
  endfunction

  // Index width needed to address DEPTH words; never less than one bit.
  function automatic int idx_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/iram_core.sv
// rtl/iram_core.sv - simple dual-port instruction array, one write port, one synchronous read port
//
// Purpose : storage only, no reset, so it can map onto block RAM.
// Ports   : clock         - clock, both ports on rising edge
//           we/waddr/wdata - write port
//           re/raddr       - read request and address
//           rdata          - registered read data, updated only when re is high
module iram_core
  import iram_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int DEPTH   = 256,
  parameter int IW      = idx_w(DEPTH)
) (
  input  logic               clock,
  input  logic               we,
  input  logic [IW-1:0]      waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic               re,
  input  logic [IW-1:0]      raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/iram_prog.sv
// rtl/iram_prog.sv - loadable instruction memory: byte-stream loader plus gated fetch port
//
// Purpose : packs a big-endian byte stream into instruction words written from
//           address 0, then serves fetches with one-cycle latency in RUN.
// Ports   : clock, reset_n            - clock, async active-low reset
//           load_start                - pulse, starts a load from RUN
//           ld_data/ld_valid/ld_ready - byte stream handshake
//           ld_last                   - final byte of the image
//           load_done                 - one-cycle pulse after the final byte
//           load_count                - words written by the current/last load
//           load_err                  - sticky overflow flag
//           busy                      - not in RUN
//           fetch_en/fetch_addr       - fetch request
//           q/q_valid                 - fetch result, q holds while q_valid is low
module iram_prog
  import iram_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 2**ADDR_W
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               load_start,
  input  logic [7:0]         ld_data,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic               ld_last,
  output logic               load_done,
  output logic [ADDR_W:0]    load_count,
  output logic               load_err,
  output logic               busy,
  input  logic               fetch_en,
  input  logic [ADDR_W-1:0]  fetch_addr,
  output logic [INSTR_W-1:0] q,
  output logic               q_valid
);

  localparam int BPW = bpw(INSTR_W);
  localparam int BCW = bcnt_w(INSTR_W);
  localparam int IW  = idx_w(DEPTH);
  localparam logic [BCW-1:0]  LAST_BYTE = BCW'(BPW - 1);
  localparam logic [ADDR_W:0] DEPTH_C   = (ADDR_W + 1)'(DEPTH);

  state_t             state;
  logic [IW-1:0]      wr_addr;
  logic [BCW-1:0]     byte_cnt;
  logic [INSTR_W-1:0] asm_q;
  logic [INSTR_W-1:0] shifted;
  logic [INSTR_W-1:0] word;
  logic [INSTR_W-1:0] rdata;
  logic               hs;
  logic               word_due;
  logic               full;
  logic               we;
  logic               in_range;
  logic               fetch_go;
  logic               have_q;
  logic               oob_q;

  assign ld_ready = (state == LOAD);
  assign busy     = (state != RUN);

  always_comb begin
    hs       = (state == LOAD) && ld_valid;
    word_due = hs && ((byte_cnt == LAST_BYTE) || ld_last);
    full     = (load_count == DEPTH_C);
    we       = word_due && !full;
    shifted  = (asm_q << 8) | INSTR_W'(ld_data);
    // A short final word is left-aligned so its unused low bytes read as zero.
    word     = shifted << (8 * (BPW - 1 - int'(byte_cnt)));
    in_range = ({1'b0, fetch_addr} < DEPTH_C);
    // A load request in the same cycle takes priority over the fetch.
    fetch_go = (state == RUN) && fetch_en && !load_start;
  end

  // The RAM output has no reset, so q is forced to zero until the first
  // serviced fetch and for any out-of-range fetch.
  assign q = (have_q && !oob_q) ? rdata : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= RUN;
      wr_addr    <= '0;
      byte_cnt   <= '0;
      asm_q      <= '0;
      load_count <= '0;
      load_err   <= 1'b0;
      load_done  <= 1'b0;
      q_valid    <= 1'b0;
      have_q     <= 1'b0;
      oob_q      <= 1'b0;
    end else begin
      load_done <= 1'b0;
      q_valid   <= fetch_go;
      if (fetch_go) begin
        have_q <= 1'b1;
        oob_q  <= !in_range;
      end
      case (state)
        RUN: begin
          if (load_start) begin
            state      <= LOAD;
            wr_addr    <= '0;
            byte_cnt   <= '0;
            asm_q      <= '0;
            load_count <= '0;
            load_err   <= 1'b0;
          end
        end
        LOAD: begin
          if (hs) begin
            if (word_due) begin
              byte_cnt <= '0;
              asm_q    <= '0;
              // Once full, the stream keeps draining but nothing more is stored.
              if (full) begin
                load_err <= 1'b1;
              end else begin
                wr_addr    <= wr_addr + 1'b1;
                load_count <= load_count + 1'b1;
              end
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
              asm_q    <= shifted;
            end
            if (ld_last) begin
              state     <= DONE;
              load_done <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= RUN;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

  iram_core #(
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH),
    .IW      (IW)
  ) u_core (
    .clock (clock),
    .we    (we),
    .waddr (wr_addr),
    .wdata (word),
    .re    (fetch_go && in_range),
    .raddr (fetch_addr[IW-1:0]),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_iram_prog.sv
// tb/tb_iram_prog.sv - randomized self-checking bench for iram_prog against a behavioural model
module tb_iram_prog;

  localparam int BPW = 2;
  localparam int DEP = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        load_start;
  logic [7:0]  ld_data;
  logic        ld_valid;
  logic        ld_ready;
  logic        ld_last;
  logic        load_done;
  logic [8:0]  load_count;
  logic        load_err;
  logic        busy;
  logic        fetch_en;
  logic [7:0]  fetch_addr;
  logic [15:0] q;
  logic        q_valid;

  int total = 0;
  int bad   = 0;
  int done_pulses = 0;
  bit chk_on = 1'b0;

  iram_prog #(.INSTR_W(16), .ADDR_W(8), .DEPTH(DEP)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .load_start (load_start),
    .ld_data    (ld_data),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_last    (ld_last),
    .load_done  (load_done),
    .load_count (load_count),
    .load_err   (load_err),
    .busy       (busy),
    .fetch_en   (fetch_en),
    .fetch_addr (fetch_addr),
    .q          (q),
    .q_valid    (q_valid)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] pack(input logic [7:0] b[$]);
    logic [15:0] w = '0;
    foreach (b[i]) w = w | (16'(b[i]) << (8 * (BPW - 1 - i)));
    return w;
  endfunction

  // Behavioural model: mode 0 = run, 1 = loading, 2 = one-cycle done.
  int          m_mode  = 0;
  logic [15:0] m_mem [DEP];
  bit          m_wr [DEP];
  logic [7:0]  m_bytes [$];
  int          m_count = 0;
  bit          m_err   = 1'b0;
  bit          m_qv    = 1'b0;
  logic [15:0] m_q     = '0;
  bit          m_qk    = 1'b1;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_mode = 0; m_count = 0; m_err = 1'b0; m_qv = 1'b0; m_q = '0; m_qk = 1'b1;
      m_bytes.delete();
    end else begin
      case (m_mode)
        0: begin
          if (load_start) begin
            m_mode = 1; m_count = 0; m_err = 1'b0; m_qv = 1'b0;
            m_bytes.delete();
          end else if (fetch_en) begin
            m_qv = 1'b1;
            if (int'(fetch_addr) >= DEP) begin
              m_q = '0; m_qk = 1'b1;
            end else if (m_wr[fetch_addr]) begin
              m_q = m_mem[fetch_addr]; m_qk = 1'b1;
            end else begin
              m_qk = 1'b0;
            end
          end else begin
            m_qv = 1'b0;
          end
        end
        1: begin
          m_qv = 1'b0;
          if (ld_valid) begin
            m_bytes.push_back(ld_data);
            if (m_bytes.size() == BPW || ld_last) begin
              if (m_count == DEP) m_err = 1'b1;
              else begin
                m_mem[m_count] = pack(m_bytes);
                m_wr[m_count]  = 1'b1;
                m_count++;
              end
              m_bytes.delete();
            end
            if (ld_last) m_mode = 2;
          end
        end
        default: begin
          m_mode = 0; m_qv = 1'b0;
        end
      endcase
    end
  end

  always @(negedge clock) begin
    if (load_done) done_pulses++;
    if (chk_on) begin
      chk("m_ready", ld_ready, m_mode == 1);
      chk("m_done", load_done, m_mode == 2);
      chk("m_busy", busy, m_mode != 0);
      chk("m_count", load_count, m_count);
      chk("m_err", load_err, m_err);
      chk("m_qvalid", q_valid, m_qv);
      if (m_qk) chk("m_q", q, m_q);
    end
  end

  task automatic clear_in();
    load_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; fetch_en = 1'b0;
  endtask

  task automatic start_load();
    @(negedge clock);
    clear_in();
    load_start = 1'b1;
  endtask

  task automatic send(input logic [7:0] img[$], input int gap_pct, input bit noise, input bit with_last);
    foreach (img[i]) begin
      int g = 0;
      while (gap_pct > 0 && g < 3 && $urandom_range(99) < gap_pct) begin
        @(negedge clock);
        g++;
        ld_valid = 1'b0; ld_data = 8'($urandom); ld_last = 1'($urandom);
        load_start = noise ? 1'($urandom) : 1'b0;
        fetch_en   = noise ? 1'($urandom) : 1'b0;
        fetch_addr = 8'($urandom_range(5));
      end
      @(negedge clock);
      clear_in();
      ld_valid = 1'b1; ld_data = img[i]; ld_last = with_last && (i == img.size() - 1);
    end
    @(negedge clock);
    clear_in();
    if (with_last) begin
      @(negedge clock);
      clear_in();
    end
  endtask

  task automatic fetch(input logic [7:0] addr);
    @(negedge clock);
    clear_in();
    fetch_en = 1'b1; fetch_addr = addr;
    @(negedge clock);
    clear_in();
  endtask

  initial begin
    logic [7:0] img [$];
    reset_n = 1'b0; ld_data = '0; fetch_addr = '0;
    clear_in();
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    chk_on = 1'b1;
    chk("rst_q", q, 16'h0);
    chk("rst_qvalid", q_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", ld_ready, 1'b0);
    chk("rst_done", load_done, 1'b0);
    chk("rst_count", load_count, 9'd0);
    chk("rst_err", load_err, 1'b0);

    fetch(8'd0);
    chk("first_fetch_qvalid", q_valid, 1'b1);

    // Full two-word image.
    img = '{8'hC0, 8'hFF, 8'h30, 8'h02};
    done_pulses = 0;
    start_load();
    send(img, 0, 1'b0, 1'b1);
    chk("img1_count", load_count, 9'd2);
    chk("img1_done_pulses", done_pulses, 1);
    fetch(8'd0); chk("img1_addr0", q, 16'hC0FF);
    fetch(8'd1); chk("img1_addr1", q, 16'h3002);

    // Odd byte count: final word zero-padded.
    img = '{8'hAA, 8'hBB, 8'hCC};
    start_load();
    send(img, 0, 1'b0, 1'b1);
    chk("img2_count", load_count, 9'd2);
    fetch(8'd0); chk("img2_addr0", q, 16'hAABB);
    fetch(8'd1); chk("img2_addr1", q, 16'hCC00);

    // Overflow: 10 bytes into 4 words.
    img.delete();
    for (int i = 0; i < 10; i++) img.push_back(8'($urandom));
    start_load();
    send(img, 0, 1'b0, 1'b1);
    chk("ovf_count", load_count, 9'd4);
    chk("ovf_err", load_err, 1'b1);
    for (int a = 0; a < 4; a++) begin
      fetch(8'(a));
      chk("ovf_word", q, {img[2*a], img[2*a+1]});
    end

    // Load and fetch colliding in one RUN cycle, then a gappy, noisy stream.
    @(negedge clock);
    clear_in();
    load_start = 1'b1; fetch_en = 1'b1; fetch_addr = 8'd0;
    @(negedge clock);
    clear_in();
    chk("collide_qvalid", q_valid, 1'b0);
    chk("collide_busy", busy, 1'b1);
    img = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    send(img, 50, 1'b1, 1'b1);
    chk("gap_count", load_count, 9'd3);
    fetch(8'd0); chk("gap_addr0", q, 16'h1234);
    fetch(8'd2); chk("gap_addr2", q, 16'h9A00);

    // Reset in the middle of a load.
    img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    start_load();
    send(img, 0, 1'b0, 1'b0);
    @(negedge clock);
    #2 reset_n = 1'b0;
    @(negedge clock);
    #2 reset_n = 1'b1;
    @(negedge clock);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_count", load_count, 9'd0);
    fetch(8'd0); chk("rst_mid_addr0", q, 16'h1122);
    fetch(8'd1); chk("rst_mid_addr1", q, 16'h3344);
    img = '{8'h9A, 8'hBC};
    start_load();
    send(img, 0, 1'b0, 1'b1);
    chk("reload_count", load_count, 9'd1);
    fetch(8'd0); chk("reload_addr0", q, 16'h9ABC);
    fetch(8'd1); chk("reload_addr1", q, 16'h3344);

    // Out-of-range fetch reads zero.
    fetch(8'd200);
    chk("oob_q", q, 16'h0);
    chk("oob_qvalid", q_valid, 1'b1);

    // Random images with gaps and noise; model checks every cycle.
    for (int n = 0; n < 20; n++) begin
      int len;
      len = $urandom_range(1, 11);
      img.delete();
      for (int i = 0; i < len; i++) img.push_back(8'($urandom));
      start_load();
      send(img, 30, 1'b1, 1'b1);
      for (int a = 0; a < 6; a++) fetch(8'(a));
    end

    repeat (2) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
